// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Shared DSP ALU definitions: FSM state encoding and default datapath width.
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

`default_nettype wire

// File: rtl/full_adder_cell.sv
// ============================================================================
// Module : full_adder_cell
// Single-bit combinational full adder, the additive twin of the subtractor cell.
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder_cell (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module : serial_adder
// Bit-serial LSB-first two's-complement adder with carry-out and overflow flags.
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int             CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  C_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  C_PENULT = CW'(WIDTH - 2);

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_psum;
  logic [WIDTH-1:0]  r_sum;
  logic [CW-1:0]     r_cnt;
  logic              r_carry;
  logic              r_cmsb;
  logic              r_cout;
  logic              r_ovf;
  logic              w_s;
  logic              w_co;

  full_adder_cell u_fa (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Cin  (r_carry),
    .S    (w_s),
    .Cout (w_co)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == C_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cmsb  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_psum  <= '0;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_psum  <= {w_s, r_psum[WIDTH-1:1]};
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == C_PENULT) r_cmsb <= w_co;
          // Result registers load on the edge that enters DONE so they are valid with done.
          if (r_cnt == C_LAST) begin
            r_sum  <= {w_s, r_psum[WIDTH-1:1]};
            r_cout <= w_co;
            r_ovf  <= r_cmsb ^ w_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases, abort-on-reset and
// randomised back-to-back operations against an A+B+Cin scoreboard.
`default_nettype none

module tb_serial_adder;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           done_seen = 0;
  int           done_exp = 0;
  logic [W-1:0] last_sum = '0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a),
    .B     (b),
    .Cin   (cin),
    .busy  (busy),
    .done  (done),
    .Sum   (sum),
    .Cout  (cout),
    .Ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive a start at a falling edge and push the reference result.
  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    logic [W:0] full;
    exp_t       e;
    a     = ia;
    b     = ib;
    cin   = ic;
    start = 1'b1;
    full  = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ic};
    e.s   = full[W-1:0];
    e.co  = full[W];
    e.ov  = (ia[W-1] == ib[W-1]) && (full[W-1] != ia[W-1]);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycle 1 is the first falling edge after the accepting edge. Optional start
  // re-pulses at inj1/inj2 carry A=FFFF and must be ignored.
  task automatic wait_done(input string tag, input int inj1, input int inj2);
    int   nbusy;
    int   cyc;
    bit   got;
    exp_t e;
    nbusy = 0;
    got   = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == inj1 || cyc == inj2) begin
        a = '1; b = '1; cin = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (cyc == 5) chk({tag, " sum_held"}, 64'(sum), 64'(last_sum));
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      if (busy === 1'b1) nbusy++;
      @(negedge clk);
    end
    chk({tag, " done_seen"}, 64'(got), 64'd1);
    if (got) begin
      chk({tag, " latency"}, 64'(cyc), 64'(W + 1));
      chk({tag, " busy_cycles"}, 64'(nbusy), 64'(W));
      chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, " Sum"}, 64'(sum), 64'(e.s));
        chk({tag, " Cout"}, 64'(cout), 64'(e.co));
        chk({tag, " Ovf"}, 64'(ovf), 64'(e.ov));
        last_sum = e.s;
        done_exp++;
      end
      @(negedge clk);
      start = 1'b0;
      chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
    end else begin
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset Sum", 64'(sum), 64'd0);
    chk("reset Cout", 64'(cout), 64'd0);
    chk("reset Ovf", 64'(ovf), 64'd0);
    @(negedge clk);

    start_op(16'h1234, 16'h4321, 1'b0); wait_done("t1", 0, 0);
    start_op(16'hFFFF, 16'h0001, 1'b0); wait_done("t2a", 0, 0);
    start_op(16'h0000, 16'h0000, 1'b1); wait_done("t2b", 0, 0);
    start_op(16'h7FFF, 16'h0001, 1'b0); wait_done("t3a", 0, 0);
    start_op(16'h8000, 16'h8000, 1'b0); wait_done("t3b", 0, 0);

    start_op(16'h0010, 16'h0020, 1'b0); wait_done("t4", 3, 17);
    chk("t4 idle_after_ignored", 64'(busy), 64'd0);
    chk("t4 done_total", 64'(done_seen), 64'(done_exp));

    // Abort mid-run: rst high across the edge ending RUN cycle 5.
    start_op(16'h1111, 16'h2222, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("t5 busy", 64'(busy), 64'd0);
    chk("t5 done", 64'(done), 64'd0);
    chk("t5 Sum", 64'(sum), 64'd0);
    chk("t5 Cout", 64'(cout), 64'd0);
    chk("t5 Ovf", 64'(ovf), 64'd0);
    repeat (W + 4) @(negedge clk);
    chk("t5 no_done", 64'(done_seen), 64'(done_exp));
    last_sum = '0;
    start_op(16'h0003, 16'h0004, 1'b0); wait_done("t5b", 0, 0);

    for (int i = 0; i < 1000; i++) begin
      start_op(W'($urandom), W'($urandom), 1'($urandom));
      wait_done("rnd", 0, 0);
    end

    chk("done_count", 64'(done_seen), 64'(done_exp));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
